pirq_ctrl: RTL and testbench

//  Parametrised interrupt controller, successor to the fixed 4-line dcpirq block.

---
 rtl/pirq_ctrl.sv | 135 +++++++++++++
 tb/tb_pirq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pirq_ctrl.sv
// Parametrised interrupt controller: per-line edge/level capture, masking, fixed or
// round-robin arbitration and a single req/ack request towards the CPU.
module pirq_ctrl #(
  parameter int NUM_IRQ   = 4,
  parameter int PRIO_MODE = 0,
  localparam int ID_W     = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_IRQ-1:0] irq_trigger,
  input  logic [NUM_IRQ-1:0] irq_edge,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_last_q, rr_last_d;
  logic [NUM_IRQ-1:0]   trig_q;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   eligible_s;
  logic [NUM_IRQ-1:0]   ack_clr_s;
  logic [ID_W-1:0]      win_fix_s;
  logic [ID_W-1:0]      win_rr_s;
  logic [ID_W-1:0]      winner_s;

  assign eligible_s = pending_q & ~irq_mask;

  // Only an ack of the currently presented request clears its pending bit.
  assign ack_clr_s = ((state_q == REQ) && irq_ack) ? (NUM_IRQ'(1) << id_q) : {NUM_IRQ{1'b0}};

  // Pending capture: edge lines set on a rising edge (set beats clear), level lines follow.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_edge[i]) begin
        pending_d[i] = (pending_q[i] & ~ack_clr_s[i]) | (enable & irq_trigger[i] & ~trig_q[i]);
      end else begin
        pending_d[i] = enable ? irq_trigger[i] : pending_q[i];
      end
    end
  end

  // Arbitration: fixed picks the highest eligible index, round-robin the first after rr_last.
  always_comb begin
    int idx;
    idx       = 0;
    win_fix_s = {ID_W{1'b0}};
    win_rr_s  = {ID_W{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      win_fix_s = eligible_s[i] ? ID_W'(i) : win_fix_s;
    end
    // Walk from the farthest offset to the nearest so the nearest eligible line wins.
    for (int k = NUM_IRQ; k >= 1; k--) begin
      idx = int'(rr_last_q) + k;
      if (idx >= NUM_IRQ) begin
        idx = idx - NUM_IRQ;
      end else begin
        idx = idx;
      end
      win_rr_s = eligible_s[idx] ? ID_W'(idx) : win_rr_s;
    end
    if (PRIO_MODE == 1) begin
      winner_s = win_rr_s;
    end else begin
      winner_s = win_fix_s;
    end
  end

  // Request FSM: the ID is frozen while a request is outstanding.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (enable && (|eligible_s)) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = winner_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          rr_last_d = id_q;
        end else begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      id_q      <= {ID_W{1'b0}};
      rr_last_q <= ID_W'(NUM_IRQ - 1);
      trig_q    <= {NUM_IRQ{1'b0}};
      pending_q <= {NUM_IRQ{1'b0}};
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
      trig_q    <= irq_trigger;
      pending_q <= pending_d;
    end
  end

  assign irq_req     = req_q;
  assign irq_id      = id_q;
  assign irq_pending = pending_q;

endmodule

// File: tb/tb_pirq_ctrl.sv
// Directed bench for pirq_ctrl: a fixed-priority and a round-robin instance share stimulus.
module tb_pirq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] trig;
  logic [3:0] edge_m;
  logic [3:0] mask;
  logic       ack;
  logic       req_f, req_r;
  logic [1:0] id_f, id_r;
  logic [3:0] pend_f, pend_r;
  int         n_tests;
  int         n_fail;

  pirq_ctrl #(.NUM_IRQ(4), .PRIO_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .enable(enable), .irq_trigger(trig), .irq_edge(edge_m),
    .irq_mask(mask), .irq_ack(ack), .irq_req(req_f), .irq_id(id_f), .irq_pending(pend_f)
  );

  pirq_ctrl #(.NUM_IRQ(4), .PRIO_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .irq_trigger(trig), .irq_edge(edge_m),
    .irq_mask(mask), .irq_ack(ack), .irq_req(req_r), .irq_id(id_r), .irq_pending(pend_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    trig   = 4'b0000;
    ack    = 1'b0;
    enable = 1'b1;
    edge_m = 4'b1111;
    mask   = 4'b0000;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    logic [1:0] prev;
    n_tests = 0;
    n_fail  = 0;
    rr_exp[0] = 2'd1; rr_exp[1] = 2'd2; rr_exp[2] = 2'd3; rr_exp[3] = 2'd0;

    // 1: single edge pulse on line 3
    do_reset();
    check("rst_req", {31'd0, req_f}, 32'd0);
    check("rst_id", {30'd0, id_f}, 32'd0);
    check("rst_pend", {28'd0, pend_f}, 32'd0);
    trig = 4'b1000;
    tick();
    trig = 4'b0000;
    check("t1_pend", {28'd0, pend_f}, 32'h8);
    check("t1_noreq_yet", {31'd0, req_f}, 32'd0);
    tick();
    check("t1_req", {31'd0, req_f}, 32'd1);
    check("t1_id", {30'd0, id_f}, 32'd3);
    tick(3);
    check("t1_hold", {31'd0, req_f}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_ackreq", {31'd0, req_f}, 32'd0);
    check("t1_ackpend", {28'd0, pend_f}, 32'd0);
    tick(3);
    check("t1_nosecond", {31'd0, req_f}, 32'd0);

    // 2: fixed priority, lines 2 and 0
    do_reset();
    trig = 4'b0101;
    tick();
    trig = 4'b0000;
    tick();
    check("t2_id2", {30'd0, id_f}, 32'd2);
    check("t2_req", {31'd0, req_f}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_idle", {31'd0, req_f}, 32'd0);
    check("t2_pend", {28'd0, pend_f}, 32'h1);
    tick();
    check("t2_req0", {31'd0, req_f}, 32'd1);
    check("t2_id0", {30'd0, id_f}, 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(2);
    check("t2_end", {31'd0, req_f}, 32'd0);
    check("t2_endpend", {28'd0, pend_f}, 32'd0);

    // 3: round-robin grant order 0,1,2,3,0
    do_reset();
    trig = 4'b1111;
    tick();
    trig = 4'b0000;
    tick();
    check("t3_rr_first", {30'd0, id_r}, 32'd0);
    prev = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("t3_rr_gap", {31'd0, req_r}, 32'd0);
      trig = 4'b0001 << prev;
      tick();
      trig = 4'b0000;
      check("t3_rr_req", {31'd0, req_r}, 32'd1);
      check("t3_rr_id", {30'd0, id_r}, {30'd0, rr_exp[i]});
      prev = rr_exp[i];
    end

    // 4: masked line captured but not requested until unmasked
    do_reset();
    mask = 4'b1000;
    trig = 4'b1000;
    tick();
    trig = 4'b0000;
    tick(3);
    check("t4_masked", {31'd0, req_f}, 32'd0);
    check("t4_pend", {28'd0, pend_f}, 32'h8);
    mask = 4'b0000;
    tick();
    check("t4_req", {31'd0, req_f}, 32'd1);
    check("t4_id", {30'd0, id_f}, 32'd3);

    // 5: level line 1
    do_reset();
    edge_m = 4'b1101;
    trig = 4'b0010;
    tick(2);
    check("t5_req", {31'd0, req_f}, 32'd1);
    check("t5_id", {30'd0, id_f}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t5_gap", {31'd0, req_f}, 32'd0);
    check("t5_lvlpend", {28'd0, pend_f}, 32'h2);
    tick();
    check("t5_rereq", {31'd0, req_f}, 32'd1);
    check("t5_reid", {30'd0, id_f}, 32'd1);
    trig = 4'b0000;
    tick();
    check("t5_drop_pend", {28'd0, pend_f}, 32'd0);
    check("t5_drop_req", {31'd0, req_f}, 32'd1);
    check("t5_drop_id", {30'd0, id_f}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(2);
    check("t5_end", {31'd0, req_f}, 32'd0);

    // 6: asynchronous reset mid-request, then no capture while disabled
    do_reset();
    trig = 4'b1000;
    tick();
    trig = 4'b0000;
    tick();
    check("t6_pre", {30'd0, id_f}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, req_f}, 32'd0);
    check("t6_rst_id", {30'd0, id_f}, 32'd0);
    check("t6_rst_pend", {28'd0, pend_f}, 32'd0);
    #3;
    rst_n = 1'b1;
    enable = 1'b0;
    tick();
    trig = 4'b0100;
    tick();
    trig = 4'b0000;
    tick(2);
    check("t6_dis_pend", {28'd0, pend_f}, 32'd0);
    check("t6_dis_req", {31'd0, req_f}, 32'd0);
    enable = 1'b1;
    tick(2);
    check("t6_en_req", {31'd0, req_f}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
